conv_window_sched: RTL and testbench
====================================

Name: conv_window_sched

Overview:
Frame-level controller that sequences the 3x3, 3-input-channel, 8-output-channel conv datapath, stride 1, no padding.
- Accepts a raster stream of multi-channel pixels and builds 3x3 windows using two line buffers and a column shift window.
- Issues each window to the datapath with a valid pulse, captures the datapath result on its ready echo, and buffers it.
- Presents results on a valid/ready output stream and regulates input by credit, so the non-stallable datapath never overruns the result buffer.

Parameters:
IMG_W, 8, pixels per row (>=3)
IMG_H, 8, rows per frame (>=3)
CH, 3, input channels
ACT_W, 8, bits per activation
OUT_W, 64, datapath result width (8 channels x 8 bits)
RES_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin frame; honoured only in IDLE
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when the frame is complete
pix_valid  in  1  input pixel valid
pix_ready  out  1  input pixel accepted when valid&ready
pix_data  in  CH*ACT_W  channel c at [c*ACT_W +: ACT_W]
conv_valid  out  1  window issue strobe to datapath
conv_act  out  9*CH*ACT_W  packed window (216 bits at defaults)
conv_ready  in  1  datapath result-valid echo
conv_result  in  OUT_W  datapath result, sampled when conv_ready=1
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  OUT_W  FIFO head
res_last  out  1  high with the final result of the frame

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on the clk rising edge only.
- Reset values: state=IDLE, all counters 0, FIFO empty, in-flight count 0. Outputs pix_ready, conv_valid, res_valid, res_last, busy and done are 0; conv_act and res_data are 0.
- A reset asserted mid-frame aborts the frame. All in-flight and buffered results are discarded. Any conv_ready arriving in the cycle after reset is ignored.
- States:
  - IDLE: start -> RUN. On entry to RUN, clear row, col, out_cnt and in-flight count.
  - RUN: accept pixels. When the accepted pixel is (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: when in-flight=0, the FIFO is empty and the last result has been popped -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored.
- Counters: col wraps at IMG_W-1 to 0 and row increments; row stops at IMG_H-1.
- Line buffers: two IMG_W-deep, CH*ACT_W-wide buffers holding rows r-1 and r-2.
- Column window: a 3-column shift register with 3 rows per column, updated on each accepted pixel.
- Window generation: an accepted pixel at (r,c) with r>=2 and c>=2 completes a window. conv_valid=1 in the next cycle, held for exactly one cycle.
  - conv_act is registered and held until the next issue.
  - Windows per frame: (IMG_H-2)*(IMG_W-2), which is 36 at defaults.
- Packing:
  - Channel c occupies conv_act[c*72 +: 72].
  - Within a channel, tap k = ky*3+kx occupies [k*8 +: 8].
  - ky=0 is row r-2, kx=0 is column c-2.
- Datapath latency: conv_ready returns exactly 1 cycle after conv_valid. The result is written to the FIFO on that cycle.
  - Datapath latency is a package constant; in-flight tracking is sized to it.
  - conv_ready with in-flight=0 is ignored.
- Credit rule: pix_ready = RUN && (pixel does not complete a window || fifo_count + in_flight < RES_DEPTH). This guarantees a FIFO write never hits full.
- Output FIFO:
  - res_valid = !empty.
  - Pop when res_valid && res_ready.
  - A push and pop in the same cycle leave the count unchanged.
  - A write into an empty FIFO gives res_valid=1 in the following cycle.
  - End-to-end latency from pixel accept to res_valid is 3 cycles when the FIFO is empty.
- res_last = res_valid && head is the final result, i.e. out_cnt == total-1, counted at pop.
- A res_ready=0 of any length never loses or reorders results.

Decomposition:
- Package conv_sched_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - the DP_LATENCY=1 constant
  - the KERNEL=3 constant
  - the pixel_t and window-width localparam helpers
- Sub-module sched_res_fifo: a synchronous FIFO with count output, parameterised width and depth. Everything else stays in the top.

Test Plan:
- 8x8 frame, pixel value p(r,c,ch) = (r*8 + c + ch*64) mod 256, res_ready=1, conv model returns a window checksum.
  - First conv_valid comes 1 cycle after pixel (2,2) is accepted.
  - conv_act[7:0]=0, [71:64]=18, [79:72]=64.
  - 36 results arrive in order; res_last is on the 36th; done pulses 1 cycle after the final pop.
- res_ready held 0 from frame start.
  - Exactly 4 windows issue.
  - pix_ready drops at the next window-completing pixel while non-window pixels are still accepted.
  - Releasing res_ready yields all 36 results with none lost.
- Random pix_valid gaps (50%) plus random res_ready.
  - Results match the reference model bit-exactly.
  - fifo_count never exceeds 4.
- rst asserted for 1 cycle after 20 windows.
  - Next cycle: all outputs 0 and state IDLE.
  - A new start yields a clean 36-result frame with no stale data.
- start pulsed during RUN and DRAIN is ignored (result count stays 36). A stray conv_ready with nothing in flight does not write the FIFO.
- IMG_W=3, IMG_H=3: a single window; res_last and done occur on the one result.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the 3x3 conv window scheduler.
// Window geometry, datapath latency and FSM states live here.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DP_LATENCY = 1;
  localparam int KERNEL = 3;

  localparam int DEF_CH = 3;
  localparam int DEF_ACT_W = 8;

  typedef logic [DEF_CH*DEF_ACT_W-1:0] pixel_t;

  function automatic int pix_w(
    input int ch,
    input int act_w
  );
    return ch * act_w;
  endfunction

  function automatic int win_w(
    input int ch,
    input int act_w
  );
    return KERNEL * KERNEL * ch * act_w;
  endfunction

endpackage

// File: rtl/conv_window_sched_fifo.sv
// Result FIFO for the conv scheduler.
// Synchronous, with occupancy count for the credit check.
module sched_res_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          pop_ok;

  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign rdata  = empty ? '0 : mem[rp];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop_ok) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/conv_window_sched.sv
// Frame sequencer for the 3x3 conv datapath: windowing,
// issue/capture, result buffering and credit-based input flow.
module conv_window_sched
  import conv_sched_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CH = 3,
  parameter int ACT_W = 8,
  parameter int OUT_W = 64,
  parameter int RES_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [CH*ACT_W-1:0]    pix_data,
  output logic                   conv_valid,
  output logic [9*CH*ACT_W-1:0]  conv_act,
  input  logic                   conv_ready,
  input  logic [OUT_W-1:0]       conv_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OUT_W-1:0]       res_data,
  output logic                   res_last
);

  localparam int PW = pix_w(CH, ACT_W);
  localparam int WW = win_w(CH, ACT_W);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int TOTAL =
    (IMG_H - KERNEL + 1) * (IMG_W - KERNEL + 1);
  localparam int OW = $clog2(TOTAL + 1);
  localparam int IFW = $clog2(DP_LATENCY + 2);
  localparam int FCW = $clog2(RES_DEPTH) + 1;
  localparam int NT = KERNEL * KERNEL;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(KERNEL - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(KERNEL - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(TOTAL - 1);
  localparam logic [OW-1:0] OUT_ALL = OW'(TOTAL);

  state_t         state;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [OW-1:0]  out_cnt;
  logic [IFW-1:0] in_flight;

  logic [PW-1:0]  lb1 [IMG_W];
  logic [PW-1:0]  lb2 [IMG_W];
  logic [PW-1:0]  wc1 [KERNEL];
  logic [PW-1:0]  wc2 [KERNEL];
  logic [PW-1:0]  nc  [KERNEL];
  logic [WW-1:0]  act_next;

  logic [FCW-1:0] fifo_cnt;
  logic           fifo_empty;
  logic           win_done;
  logic           credit_ok;
  logic           accept;
  logic           issue;
  logic           push;
  logic           pop;
  logic           last_px;
  logic           drain_fin;

  assign win_done  = (row >= ROW_EDGE) && (col >= COL_EDGE);
  assign credit_ok =
    (32'(fifo_cnt) + 32'(in_flight)) < 32'(RES_DEPTH);
  assign pix_ready =
    (state == RUN) && (!win_done || credit_ok);
  assign accept    = pix_valid && pix_ready;
  assign issue     = accept && win_done;
  assign push      = conv_ready && (in_flight != '0);
  assign res_valid = !fifo_empty;
  assign pop       = res_valid && res_ready;
  assign res_last  = res_valid && (out_cnt == OUT_LAST);
  assign last_px   = (row == ROW_LAST) && (col == COL_LAST);

  // The final pop is looked ahead so done follows it directly.
  assign drain_fin = (in_flight == '0) &&
    ((fifo_empty && out_cnt == OUT_ALL) ||
     (pop && fifo_cnt == FCW'(1) && out_cnt == OUT_LAST));

  // incoming column: rows r-2, r-1 and the live pixel
  always_comb begin
    nc[0] = lb2[col];
    nc[1] = lb1[col];
    nc[2] = pix_data;
  end

  // pack channel-major, then ky, then kx
  always_comb begin
    act_next = '0;
    for (int c = 0; c < CH; c++) begin
      for (int ky = 0; ky < KERNEL; ky++) begin
        act_next[(c*NT + ky*KERNEL + 0)*ACT_W +: ACT_W] =
          wc1[ky][c*ACT_W +: ACT_W];
        act_next[(c*NT + ky*KERNEL + 1)*ACT_W +: ACT_W] =
          wc2[ky][c*ACT_W +: ACT_W];
        act_next[(c*NT + ky*KERNEL + 2)*ACT_W +: ACT_W] =
          nc[ky][c*ACT_W +: ACT_W];
      end
    end
  end

  // line buffers and column shift window
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pix_data;
      wc1 <= wc2;
      wc2 <= nc;
    end
  end

  // frame FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      out_cnt    <= '0;
      in_flight  <= '0;
      conv_valid <= 1'b0;
      conv_act   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      conv_valid <= issue;
      if (issue) conv_act <= act_next;
      in_flight <= in_flight + IFW'(issue) - IFW'(push);
      if (pop) out_cnt <= out_cnt + OW'(1);
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            row       <= '0;
            col       <= '0;
            out_cnt   <= '0;
            in_flight <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row != ROW_LAST) row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (last_px) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sched_res_fifo #(
    .W(OUT_W),
    .DEPTH(RES_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(conv_result),
    .rdata(res_data),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched.
// Image-array reference model, emulated datapath, 3x3 corner case.
module tb_conv_window_sched;

  localparam int W = 8;
  localparam int H = 8;
  localparam int TOT = 36;
  localparam int DEPTH = 4;

  logic clk, rst, start, busy, done;
  logic pix_valid, pix_ready;
  logic [23:0] pix_data;
  logic conv_valid, conv_ready;
  logic [215:0] conv_act;
  logic [63:0] conv_result, res_data;
  logic res_valid, res_ready, res_last;

  logic start_s, busy_s, done_s;
  logic pix_valid_s, pix_ready_s;
  logic [23:0] pix_data_s;
  logic conv_valid_s, conv_ready_s;
  logic [215:0] conv_act_s;
  logic [63:0] conv_result_s, res_data_s;
  logic res_valid_s, res_ready_s, res_last_s;

  conv_window_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data),
    .conv_valid(conv_valid), .conv_act(conv_act),
    .conv_ready(conv_ready), .conv_result(conv_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last)
  );

  conv_window_sched #(.IMG_W(3), .IMG_H(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s),
    .busy(busy_s), .done(done_s),
    .pix_valid(pix_valid_s), .pix_ready(pix_ready_s),
    .pix_data(pix_data_s),
    .conv_valid(conv_valid_s), .conv_act(conv_act_s),
    .conv_ready(conv_ready_s), .conv_result(conv_result_s),
    .res_valid(res_valid_s), .res_ready(res_ready_s),
    .res_data(res_data_s), .res_last(res_last_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] img [H][W][3];

  int q_iss[$];
  logic [215:0] q_act[$];
  logic [63:0] q_res[$];
  bit q_last[$];

  int acc, n_iss, pops, occ, done_due, done_cnt;
  bit pat_mode, abort, stray, rr_rand, rr_fixed;
  bit cv_cap, rst_cap, echo_real, cv3_cap;
  logic [215:0] act_cap, act3_cap;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] chk(input logic [215:0] a);
    logic [63:0] r;
    logic [15:0] s;
    r = '0;
    for (int o = 0; o < 8; o++) begin
      s = 0;
      for (int i = 0; i < 27; i++)
        s = s + 16'(a[i*8 +: 8]) * 16'(i + 1 + 3*o);
      r[o*8 +: 8] = s[7:0] ^ 8'(o);
    end
    return r;
  endfunction

  function automatic logic [215:0] win_act(input int r, input int c);
    logic [215:0] a;
    a = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          a[(ch*9 + ky*3 + kx)*8 +: 8] = img[r-2+ky][c-2+kx][ch];
    return a;
  endfunction

  function automatic logic [23:0] pix(input int r, input int c);
    return {img[r][c][2], img[r][c][1], img[r][c][0]};
  endfunction

  // emulated datapath: echoes one cycle after each issue
  always @(negedge clk) begin
    cv_cap = conv_valid;
    act_cap = conv_act;
    rst_cap = rst;
    cv3_cap = conv_valid_s;
    act3_cap = conv_act_s;
  end

  always @(posedge clk) begin
    #1;
    conv_ready = cv_cap || stray;
    echo_real = cv_cap && !rst_cap;
    conv_result = cv_cap ? chk(act_cap) : 64'hdead_beef_0bad_f00d;
    conv_ready_s = cv3_cap;
    conv_result_s = chk(act3_cap);
  end

  always @(posedge clk) begin
    #1;
    res_ready = rr_rand ? 1'($urandom_range(1)) : rr_fixed;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    int ec, r, c;
    bit popped, el;
    logic [215:0] ea, wa;
    logic [63:0] er;
    if (rst) begin
      q_iss.delete(); q_act.delete();
      q_res.delete(); q_last.delete();
      occ = 0; acc = 0; n_iss = 0; pops = 0; done_due = -1;
    end else begin
      if (start && !busy && !done) begin
        acc = 0; n_iss = 0; pops = 0;
      end
      if (conv_valid) begin
        if (q_iss.size() == 0) begin
          check(0, "conv_valid_spurious", 1, 0);
        end else begin
          ec = q_iss.pop_front();
          ea = q_act.pop_front();
          check(cyc == ec, "issue_cycle", cyc, ec);
          check(conv_act == ea, "conv_act", conv_act, ea);
          if (pat_mode && n_iss == 0) begin
            check(conv_act[7:0] == 8'd0, "act_b0", conv_act[7:0], 0);
            check(conv_act[71:64] == 8'd18, "act_b8",
                  conv_act[71:64], 18);
            check(conv_act[79:72] == 8'd64, "act_b9",
                  conv_act[79:72], 64);
          end
        end
        n_iss++;
      end
      check(res_valid == (occ != 0), "res_valid", res_valid, occ != 0);
      check(occ <= DEPTH, "fifo_bound", occ, DEPTH);
      check(!res_last || res_valid, "last_wo_valid", res_last, 0);
      popped = 0;
      if (res_valid && res_ready) begin
        if (q_res.size() == 0) begin
          check(0, "extra_result", res_data, 0);
        end else begin
          er = q_res.pop_front();
          el = q_last.pop_front();
          check(res_data == er, "res_data", res_data, er);
          check(res_last == el, "res_last", res_last, el);
          if (el) done_due = cyc + 1;
        end
        pops++;
        popped = 1;
      end
      if (done || (done_due >= 0 && cyc == done_due)) begin
        check(done && cyc == done_due, "done_pulse", done, 1);
        if (done) done_cnt++;
        done_due = -1;
      end
      if (pix_valid && pix_ready) begin
        r = acc / W;
        c = acc % W;
        if (r >= 2 && c >= 2) begin
          wa = win_act(r, c);
          q_iss.push_back(cyc + 1);
          q_act.push_back(wa);
          q_res.push_back(chk(wa));
          q_last.push_back(r == H-1 && c == W-1);
        end
        acc++;
      end
      occ = occ + (echo_real ? 1 : 0) - (popped ? 1 : 0);
    end
  end

  task automatic send_frame(input int gap);
    bit ok;
    for (int i = 0; i < W*H; i++) begin
      while ($urandom_range(99) < gap) begin
        pix_valid = 0;
        @(posedge clk); #1;
        if (abort) return;
      end
      pix_valid = 1;
      pix_data = pix(i / W, i % W);
      ok = 0;
      for (int w = 0; w < 2000 && !ok; w++) begin
        @(negedge clk);
        ok = pix_ready;
        @(posedge clk); #1;
        if (abort) begin
          pix_valid = 0;
          return;
        end
      end
      if (!ok) begin
        check(0, "pix_timeout", i, 0);
        pix_valid = 0;
        return;
      end
    end
    pix_valid = 0;
  endtask

  task automatic start_pulse();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == d0; i++)
      @(negedge clk);
    check(done_cnt != d0, "done_timeout", done_cnt, d0 + 1);
    @(posedge clk); #1;
  endtask

  task automatic end_frame(input string tag);
    check(pops == TOT, {tag, "_count"}, pops, TOT);
    check(q_res.size() == 0, {tag, "_left"}, q_res.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    check(!pix_ready && !conv_valid && !res_valid, {tag, "_hs"},
          {pix_ready, conv_valid, res_valid}, 0);
    check(!res_last && !busy && !done, {tag, "_st"},
          {res_last, busy, done}, 0);
    check(conv_act == '0, {tag, "_act"}, conv_act, 0);
    check(res_data == '0, {tag, "_data"}, res_data, 0);
  endtask

  task automatic pat_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < 3; ch++)
          img[r][c][ch] = 8'((r*8 + c + ch*64) % 256);
  endtask

  task automatic rnd_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < 3; ch++)
          img[r][c][ch] = 8'($urandom);
  endtask

  initial begin
    logic [63:0] exp_s;
    bit got;
    rst = 1; start = 0; pix_valid = 0; pix_data = 0;
    start_s = 0; pix_valid_s = 0; pix_data_s = 0; res_ready_s = 1;
    abort = 0; stray = 0; rr_rand = 0; rr_fixed = 1; pat_mode = 0;
    done_cnt = 0; done_due = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 0;

    // stray echo with nothing in flight
    @(negedge clk); stray = 1;
    @(negedge clk); stray = 0;
    repeat (2) @(negedge clk);
    check(res_valid == 0, "stray_write", res_valid, 0);
    @(posedge clk); #1;

    // ramp image, consumer always ready
    pat_img();
    pat_mode = 1;
    start_pulse();
    send_frame(0);
    wait_done();
    pat_mode = 0;
    end_frame("ramp");

    // consumer stalled from frame start
    rr_fixed = 0;
    @(posedge clk); #1;
    start_pulse();
    fork
      send_frame(0);
      begin
        repeat (200) @(negedge clk);
        check(n_iss == 4, "stall_issues", n_iss, 4);
        check(acc == 22, "stall_accepts", acc, 22);
        check(pix_ready == 0, "stall_ready", pix_ready, 0);
        rr_fixed = 1;
      end
    join
    wait_done();
    end_frame("stall");

    // random gaps and random consumer
    rr_rand = 1;
    for (int f = 0; f < 2; f++) begin
      rnd_img();
      start_pulse();
      send_frame(50);
      wait_done();
      end_frame("random");
    end

    // reset mid-frame after 20 windows
    pat_img();
    start_pulse();
    fork
      send_frame(20);
      begin
        for (int i = 0; i < 2000 && n_iss < 20; i++)
          @(negedge clk);
        check(n_iss >= 20, "rst_wait", n_iss, 20);
        abort = 1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk_idle("midrst");
      end
    join
    abort = 0;
    @(posedge clk); #1;
    rnd_img();
    start_pulse();
    send_frame(30);
    wait_done();
    end_frame("after_rst");

    // start pulses during RUN and DRAIN
    pat_img();
    start_pulse();
    fork
      send_frame(30);
      begin
        repeat (25) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1;
        start = 0;
      end
    join
    start = 1;
    @(negedge clk);
    check(busy == 1, "drain_busy", busy, 1);
    @(posedge clk); #1;
    start = 0;
    wait_done();
    repeat (20) @(negedge clk);
    end_frame("restart");
    check(busy == 0, "restart_idle", busy, 0);
    @(posedge clk); #1;

    // 3x3 frame: one window
    exp_s = chk(win_act(2, 2));
    start_s = 1;
    @(posedge clk); #1;
    start_s = 0;
    for (int i = 0; i < 9; i++) begin
      pix_valid_s = 1;
      pix_data_s = pix(i / 3, i % 3);
      @(negedge clk);
      check(pix_ready_s == 1, "s_ready", pix_ready_s, 1);
      @(posedge clk); #1;
    end
    pix_valid_s = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (res_valid_s) begin
        got = 1;
        check(res_data_s == exp_s, "s_data", res_data_s, exp_s);
        check(res_last_s == 1, "s_last", res_last_s, 1);
        @(negedge clk);
        check(done_s == 1, "s_done", done_s, 1);
        @(negedge clk);
        check(busy_s == 0, "s_idle", busy_s, 0);
      end
    end
    check(got, "s_timeout", got, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
